// File: rtl/bootloader_pkg.sv
// Shared types and default sizing for the serial program-memory bootloader.
package bootloader_pkg;

  localparam int DEFAULT_DATA_WIDTH       = 4;
  localparam int DEFAULT_ADDR_WIDTH       = 4;
  localparam int DEFAULT_MEMORY_REGISTERS = 16;
  localparam int DEFAULT_SYNC_STAGES      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } bl_state_e;

endpackage

// File: rtl/bootloader_if.sv
// Board-side request pins and CPU-memory write port of the bootloader, plus its FSM state for observation.
interface bootloader_if
  import bootloader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  // enable_i/strobe_i/data_i are asynchronous; a word is offered by a rising
  // strobe_i edge with data_i already stable and held until the next word.
  // bl_write_en_mem_o is a one-cycle pulse; data/address are valid while it is high.
  logic                  enable_i;
  logic                  strobe_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  bl_programm_o;
  logic [DATA_WIDTH-1:0] bl_data_o;
  logic [ADDR_WIDTH-1:0] bl_address_o;
  logic                  bl_write_en_mem_o;
  logic                  done_o;
  bl_state_e             state;

  modport master (
    output enable_i, strobe_i, data_i,
    input  bl_programm_o, bl_data_o, bl_address_o, bl_write_en_mem_o, done_o, state
  );

  modport slave (
    input  enable_i, strobe_i, data_i,
    output bl_programm_o, bl_data_o, bl_address_o, bl_write_en_mem_o, done_o, state
  );

endinterface

// File: rtl/bootloader_sync_ff.sv
// Multi-stage flip-flop synchronizer for asynchronous inputs, cleared by async reset.
module sync_ff #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/bootloader.sv
// Loads MEMORY_REGISTERS words, one per strobe edge, into CPU program memory while enable is held.
module bootloader
  import bootloader_pkg::*;
#(
  parameter int DATA_WIDTH           = DEFAULT_DATA_WIDTH,
  parameter int MEMORY_ADDRESS_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int MEMORY_REGISTERS     = DEFAULT_MEMORY_REGISTERS,
  parameter int SYNC_STAGES          = DEFAULT_SYNC_STAGES
) (
  input  logic         clk_i,
  input  logic         reset_i,
  bootloader_if.slave  bus
);

  localparam logic [MEMORY_ADDRESS_WIDTH-1:0] LAST_ADDR =
    MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);
  localparam logic [MEMORY_ADDRESS_WIDTH-1:0] ADDR_ONE = MEMORY_ADDRESS_WIDTH'(1);

  logic                            enable_s;
  logic                            strobe_s;
  logic [DATA_WIDTH-1:0]           data_s;
  logic                            strobe_prev;
  logic                            strobe_evt;

  bl_state_e                       state;
  logic [MEMORY_ADDRESS_WIDTH-1:0] counter;
  logic                            programm;
  logic [DATA_WIDTH-1:0]           data_q;
  logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q;
  logic                            write_en;
  logic                            done;

  sync_ff #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_sync_enable (
    .clk (clk_i),
    .rst (reset_i),
    .d   (bus.enable_i),
    .q   (enable_s)
  );

  sync_ff #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_sync_strobe (
    .clk (clk_i),
    .rst (reset_i),
    .d   (bus.strobe_i),
    .q   (strobe_s)
  );

  sync_ff #(.WIDTH(DATA_WIDTH), .DEPTH(SYNC_STAGES)) u_sync_data (
    .clk (clk_i),
    .rst (reset_i),
    .d   (bus.data_i),
    .q   (data_s)
  );

  // The edge flag is registered, so data_s has had an extra cycle to settle
  // before it is captured into bl_data_o.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      strobe_prev <= 1'b0;
      strobe_evt  <= 1'b0;
    end else begin
      strobe_prev <= strobe_s;
      strobe_evt  <= strobe_s & ~strobe_prev;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      counter  <= '0;
      programm <= 1'b0;
      data_q   <= '0;
      addr_q   <= '0;
      write_en <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          write_en <= 1'b0;
          done     <= 1'b0;
          if (enable_s) begin
            state    <= LOAD;
            counter  <= '0;
            programm <= 1'b1;
          end
        end

        LOAD: begin
          // Losing enable outranks a strobe seen in the same cycle.
          if (!enable_s) begin
            state    <= IDLE;
            counter  <= '0;
            programm <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
          end else if (strobe_evt) begin
            state    <= WRITE;
            data_q   <= data_s;
            addr_q   <= counter;
            write_en <= 1'b1;
          end
        end

        WRITE: begin
          write_en <= 1'b0;
          if (!enable_s) begin
            state    <= IDLE;
            counter  <= '0;
            programm <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
          end else if (counter == LAST_ADDR) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state   <= LOAD;
            counter <= counter + ADDR_ONE;
          end
        end

        DONE: begin
          write_en <= 1'b0;
          if (!enable_s) begin
            state    <= IDLE;
            counter  <= '0;
            programm <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            done     <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          counter  <= '0;
          programm <= 1'b0;
          data_q   <= '0;
          addr_q   <= '0;
          write_en <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bl_programm_o     = programm;
  assign bus.bl_data_o         = data_q;
  assign bus.bl_address_o      = addr_q;
  assign bus.bl_write_en_mem_o = write_en;
  assign bus.done_o            = done;
  assign bus.state             = state;

endmodule

// File: doc/bootloader.md
BOOTLOADER -- requirements
Module: bootloader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, meaning width of one program-memory word.
REQ-002 SHALL have parameter MEMORY_ADDRESS_WIDTH, default 4, meaning program-memory address width.
REQ-003 SHALL have parameter MEMORY_REGISTERS, default 16, meaning number of words loaded per session.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of input synchronizers.
REQ-005 SHALL have port clk_i  input  1  single system clock; all flops rising-edge.
REQ-006 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port enable_i  input  1  asynchronous programming-mode request from a board pin.
REQ-008 SHALL have port strobe_i  input  1  asynchronous data strobe; rising edge = one word offered.
REQ-009 SHALL have port data_i  input  DATA_WIDTH  word offered with strobe_i; held stable by source.
REQ-010 SHALL have port bl_programm_o  output  1  holds CPU in programming mode.
REQ-011 SHALL have port bl_data_o  output  DATA_WIDTH  word to write into CPU memory.
REQ-012 SHALL have port bl_address_o  output  MEMORY_ADDRESS_WIDTH  memory write address.
REQ-013 SHALL have port bl_write_en_mem_o  output  1  one-cycle memory write pulse.
REQ-014 SHALL have port done_o  output  1  all MEMORY_REGISTERS words written this session.

Function
REQ-015 SHALL pass enable_i, strobe_i and data_i each through a SYNC_STAGES-deep synchronizer before use.
REQ-016 SHALL detect a strobe event as synchronized strobe high while its previous registered value is low.
REQ-017 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-018 IDLE: outputs low/zero; synced enable high -> LOAD with address counter cleared to 0.
REQ-019 LOAD: bl_programm_o=1; strobe event -> WRITE, registering synced data_i into bl_data_o and counter into bl_address_o.
REQ-020 WRITE: bl_write_en_mem_o=1 for exactly one cycle; bl_data_o and bl_address_o stable during that cycle.
REQ-021 WRITE exit: counter == MEMORY_REGISTERS-1 -> DONE; otherwise counter+1, -> LOAD.
REQ-022 DONE: bl_programm_o=1, done_o=1; strobe events ignored; synced enable low -> IDLE.
REQ-023 Synced enable low in LOAD -> IDLE (abort), counter cleared, no write, done_o stays 0.
REQ-024 Synced enable falling in the same cycle as a strobe event in LOAD: abort wins, no write.
REQ-025 Enable dropping during WRITE: the write completes, then -> IDLE instead of LOAD/DONE.
REQ-026 Strobe events in IDLE, WRITE and DONE SHALL be ignored, never queued.
REQ-027 Latency: strobe_i first sampled high at clock edge n -> bl_write_en_mem_o high in the cycle after edge n+SYNC_STAGES+1.
REQ-028 Counter SHALL never wrap within a session; a new session starts at address 0.

Reset
REQ-029 reset_i high SHALL force IDLE, counter 0, synchronizers 0, all outputs 0, independent of clk_i.
REQ-030 reset_i mid-session SHALL abort without further writes; first session after release starts at address 0.

Structure
REQ-031 SHALL place the FSM state enum and default width constants in shared package bootloader_pkg.
REQ-032 SHALL use one sub-module, sync_ff (parameterised width and depth, async active-high reset), for all synchronizers.

Verification
REQ-033 Full load: enable=1, 16 strobes with data 0x0..0xF -> 16 single-cycle write pulses, address k carries data k, then done_o=1, bl_programm_o=1.
REQ-034 Latency: strobe rise with data 0xA at address 0 -> write pulse exactly SYNC_STAGES+2 edges later, bl_data_o=0xA.
REQ-035 Abort: 5 words written, enable=0 -> IDLE, done_o=0; re-enable and next strobe writes address 0.
REQ-036 Overrun: in DONE, 3 extra strobes -> no write pulse, done_o stays 1; enable=0 -> all outputs 0.
REQ-037 Reset mid-load: reset_i asserted after word 7 -> outputs 0 immediately without a clock edge; after release, session restarts at address 0.
REQ-038 Simultaneous enable fall and strobe event in LOAD -> no write pulse, state IDLE.
